// File: rtl/morse_rec_ctrl_if.sv
// Recorder and symbol handshake bundle for morse_rec_ctrl.
// master = controller side, slave = recorder/decoder side.
interface morse_rec_ctrl_if #(
  parameter int WID     = 32,
  parameter int MAX_SYM = 5
);
  logic                   rec_end;
  logic [4:0]             rec_count;
  logic [MAX_SYM*WID-1:0] rec_values;
  logic                   rec_rst;
  logic                   sym_valid;
  logic                   sym_ready;
  logic [MAX_SYM-1:0]     sym_code;
  logic [2:0]             sym_len;
  logic                   sym_err;

  modport master (
    input  rec_end, rec_count, rec_values, sym_ready,
    output rec_rst, sym_valid, sym_code, sym_len, sym_err
  );

  modport slave (
    output rec_end, rec_count, rec_values, sym_ready,
    input  rec_rst, sym_valid, sym_code, sym_len, sym_err
  );
endinterface

// File: rtl/morse_rec_ctrl.sv
// Morse recorder sequencer: latch pulses, classify dot/dash, hand off one symbol, reset recorder.
// Optional MORSE_CTRL_STATS_EN adds saturating stat_sym / stat_err counters.
module morse_rec_ctrl #(
  parameter int WID     = 32,
  parameter int MAX_SYM = 5,
  parameter int DASH_TH = 15,
  parameter int RST_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  morse_rec_ctrl_if.master bus
`ifdef MORSE_CTRL_STATS_EN
  ,
  output logic [15:0]     stat_sym,
  output logic [15:0]     stat_err
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_CLASSIFY = 3'd2;
  localparam logic [2:0] S_PRESENT  = 3'd3;
  localparam logic [2:0] S_CLEAR    = 3'd4;
  localparam logic [2:0] S_WAIT_LOW = 3'd5;

  localparam logic [2:0] MAX_L = 3'(MAX_SYM);

  logic [2:0]     state;
  logic [2:0]     idx;
  logic [2:0]     lat_len;
  logic [WID-1:0] val [MAX_SYM];
  logic [7:0]     rst_cnt;
  logic           over;
  logic [2:0]     clip_len;

  always_comb begin
    over     = bus.rec_count > 5'(MAX_SYM);
    clip_len = over ? MAX_L : bus.rec_count[2:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      lat_len       <= '0;
      rst_cnt       <= '0;
      bus.rec_rst   <= 1'b0;
      bus.sym_valid <= 1'b0;
      bus.sym_code  <= '0;
      bus.sym_len   <= '0;
      bus.sym_err   <= 1'b0;
      for (int i = 0; i < MAX_SYM; i++) val[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rec_end) state <= S_LATCH;
        end
        S_LATCH: begin
          for (int i = 0; i < MAX_SYM; i++) val[i] <= bus.rec_values[i*WID +: WID];
          lat_len      <= clip_len;
          idx          <= '0;
          bus.sym_code <= '0;
          if (clip_len == 3'd0) begin
            // Empty recording: nothing to present, just reset the recorder.
            bus.sym_err <= 1'b0;
            bus.rec_rst <= 1'b1;
            rst_cnt     <= '0;
            state       <= S_CLEAR;
          end else begin
            bus.sym_err <= over;
            state       <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          bus.sym_code[idx] <= (val[idx] >= WID'(DASH_TH));
          if (idx == lat_len - 3'd1) begin
            bus.sym_len   <= lat_len;
            bus.sym_valid <= 1'b1;
            state         <= S_PRESENT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_PRESENT: begin
          if (bus.sym_ready) begin
            bus.sym_valid <= 1'b0;
            bus.sym_code  <= '0;
            bus.sym_len   <= '0;
            bus.sym_err   <= 1'b0;
            bus.rec_rst   <= 1'b1;
            rst_cnt       <= '0;
            state         <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (rst_cnt == 8'(RST_CYC - 1)) begin
            bus.rec_rst <= 1'b0;
            state       <= S_WAIT_LOW;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        S_WAIT_LOW: begin
          // Hold off until the recorder drops its flag so a stale end is not reprocessed.
          if (!bus.rec_end) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MORSE_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_sym <= '0;
      stat_err <= '0;
    end else begin
      if (state == S_PRESENT && bus.sym_ready && stat_sym != 16'hFFFF)
        stat_sym <= stat_sym + 16'd1;
      if (state == S_LATCH && (over || clip_len == 3'd0) && stat_err != 16'hFFFF)
        stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_morse_rec_ctrl.sv
// Self-checking bench for morse_rec_ctrl: directed table, reset corner case, random symbols vs model.
module tb_morse_rec_ctrl;
  localparam int WID = 32, MAX_SYM = 5, RST_CYC = 2;

  logic clk;
  logic reset;
  morse_rec_ctrl_if #(.WID(WID), .MAX_SYM(MAX_SYM)) bus ();
`ifdef MORSE_CTRL_STATS_EN
  logic [15:0] stat_sym, stat_err;
  int exp_sym, exp_err;
`endif

  morse_rec_ctrl #(.WID(WID), .MAX_SYM(MAX_SYM), .DASH_TH(15), .RST_CYC(RST_CYC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MORSE_CTRL_STATS_EN
    ,
    .stat_sym(stat_sym),
    .stat_err(stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_drop = 1'b0;

  typedef struct {
    int          count;
    logic [31:0] v [5];
    int          dly;
    logic [4:0]  code;
    int          len;
    bit          err;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int count, input logic [159:0] vals,
                                output logic [4:0] code, output int len, output bit err);
    len  = (count < MAX_SYM) ? count : MAX_SYM;
    err  = (count > MAX_SYM);
    code = '0;
    for (int i = 0; i < len; i++) code[i] = (vals[i*32 +: 32] >= 32'd15);
  endfunction

  // Called just after a negedge (or between edges); runs one symbol to completion.
  task automatic run_sym(input bit set_end, input int dly, input logic [4:0] ecode,
                         input int elen, input bit eerr, input string name);
    int cyc;
    int n;
    cyc = 0;
    bus.sym_ready = (dly == 0);
    if (set_end) bus.rec_end = 1'b1;
    while (cyc < 60 && !bus.sym_valid && !bus.rec_rst) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && rand_drop) bus.rec_end = 1'($urandom_range(0, 1));
      if (cyc == 2) bus.rec_values = ~bus.rec_values;
    end
    if (elen == 0) begin
      chk({name, "_empty_rst_time"}, 32'(cyc), 32'd2);
      chk({name, "_empty_novalid"}, 32'(bus.sym_valid), 32'd0);
    end else begin
      chk({name, "_latency"}, 32'(cyc), 32'(2 + elen));
      chk({name, "_sym"}, 32'({bus.sym_valid, bus.rec_rst, bus.sym_err, bus.sym_len, bus.sym_code}),
          32'({1'b1, 1'b0, eerr, 3'(elen), ecode}));
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        chk({name, "_hold"}, 32'({bus.sym_valid, bus.rec_rst, bus.sym_err, bus.sym_len, bus.sym_code}),
            32'({1'b1, 1'b0, eerr, 3'(elen), ecode}));
      end
      bus.sym_ready = 1'b1;
      @(negedge clk);
      bus.sym_ready = 1'b0;
      chk({name, "_xfer"}, 32'({bus.sym_valid, bus.rec_rst, bus.sym_err, bus.sym_len, bus.sym_code}),
          32'({1'b0, 1'b1, 1'b0, 3'd0, 5'd0}));
    end
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      if (!bus.rec_rst) break;
      n++;
    end
    chk({name, "_rst_len"}, 32'(n), 32'(RST_CYC));
    repeat (3) begin
      @(negedge clk);
      chk({name, "_wait_low"}, 32'({bus.sym_valid, bus.rec_rst}), 32'd0);
    end
`ifdef MORSE_CTRL_STATS_EN
    if (elen != 0) exp_sym++;
    if (eerr || elen == 0) exp_err++;
    chk({name, "_stat_sym"}, 32'(stat_sym), 32'(exp_sym));
    chk({name, "_stat_err"}, 32'(stat_err), 32'(exp_err));
`endif
    bus.rec_end = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load(input int count, input logic [31:0] v [5]);
    bus.rec_count = 5'(count);
    for (int i = 0; i < 5; i++) bus.rec_values[i*32 +: 32] = v[i];
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] mcode;
    int mlen;
    bit merr;
    int cnt;

    tbl[0] = '{count: 3, v: '{14, 20, 10, 0, 0},      dly: 0,  code: 5'b00010, len: 3, err: 0};
    tbl[1] = '{count: 3, v: '{14, 20, 10, 0, 0},      dly: 10, code: 5'b00010, len: 3, err: 0};
    tbl[2] = '{count: 0, v: '{20, 20, 20, 20, 20},    dly: 0,  code: 5'b00000, len: 0, err: 0};
    tbl[3] = '{count: 7, v: '{18, 18, 18, 18, 18},    dly: 2,  code: 5'b11111, len: 5, err: 1};
    tbl[4] = '{count: 2, v: '{15, 14, 0, 0, 0},       dly: 1,  code: 5'b00001, len: 2, err: 0};
    tbl[5] = '{count: 5, v: '{0, 15, 16, 32'hFFFFFFFF, 14}, dly: 0, code: 5'b01110, len: 5, err: 0};

    reset = 1'b1;
    bus.rec_end = 1'b0;
    bus.rec_count = '0;
    bus.rec_values = '0;
    bus.sym_ready = 1'b0;
`ifdef MORSE_CTRL_STATS_EN
    exp_sym = 0;
    exp_err = 0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({bus.sym_valid, bus.rec_rst, bus.sym_err, bus.sym_len, bus.sym_code}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_quiet", 32'({bus.sym_valid, bus.rec_rst}), 32'd0);

    for (int t = 0; t < 6; t++) begin
      load(tbl[t].count, tbl[t].v);
      run_sym(1'b1, tbl[t].dly, tbl[t].code, tbl[t].len, tbl[t].err, $sformatf("vec%0d", t));
    end

    // Reset in the middle of CLASSIFY with rec_end still high: symbol must be redone.
    load(5, '{20, 3, 20, 3, 20});
    bus.rec_end = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("midreset_clear", 32'({bus.sym_valid, bus.rec_rst, bus.sym_err, bus.sym_len, bus.sym_code}), 32'd0);
`ifdef MORSE_CTRL_STATS_EN
    exp_sym = 0;
    exp_err = 0;
`endif
    #1 reset = 1'b0;
    run_sym(1'b0, 0, 5'b10101, 5, 1'b0, "midreset");

    rand_drop = 1'b1;
    for (int r = 0; r < 25; r++) begin
      logic [159:0] vals;
      cnt = $urandom_range(0, 8);
      for (int i = 0; i < 5; i++)
        vals[i*32 +: 32] = ($urandom_range(0, 4) == 0) ? $urandom() : 32'($urandom_range(0, 30));
      bus.rec_count = 5'(cnt);
      bus.rec_values = vals;
      model(cnt, vals, mcode, mlen, merr);
      run_sym(1'b1, $urandom_range(0, 4), mcode, mlen, merr, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
